// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store front-end.
// Holds the request size encodings, the FSM state type and the byte-lane
// helpers used by mem_access_unit and mem_lane_align.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Bit position of the least significant bit of the addressed lane(s).
  // Big-endian puts offset 0 in the top byte, so the lowest lane index of a
  // multi-byte access is found from its last byte, not its first.
  function automatic logic [4:0] lane_shift(input logic [1:0] off,
                                            input logic [1:0] size,
                                            input logic       be);
    logic [1:0] nb_m1;
    logic [1:0] lane;
    nb_m1 = (size == SZ_WORD) ? 2'd3 : (size == SZ_HALF) ? 2'd1 : 2'd0;
    lane  = be ? (2'd3 - off - nb_m1) : off;
    return {lane, 3'b000};
  endfunction

  // Illegal size, or address not aligned to the access size.
  function automatic logic access_err(input logic [1:0] size,
                                      input logic [1:0] off);
    return (size == 2'b10) ||
           ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: pipeline request/response handshake plus
// the word-only data_memory port.
//   slave  : the unit (consumes req_*, dm_rdata; drives the rest)
//   master : pipeline + data_memory side
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_re;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic [31:0] dm_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           dm_addr, dm_wdata, dm_re, dm_we, dm_size
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           dm_addr, dm_wdata, dm_re, dm_we, dm_size
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering.
//   rd_word/off/size/sgn -> load_data : extracted lane, sign/zero extended
//   rd_word/new_data     -> store_word: rd_word with addressed lane(s) replaced
// Word size passes straight through / replaces the whole word.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] rd_word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  always_comb begin
    sh      = lane_shift(off, size, BIG_ENDIAN);
    shifted = rd_word >> sh;
    case (size)
      SZ_BYTE: begin
        mask      = 32'h0000_00FF;
        load_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        mask      = 32'h0000_FFFF;
        load_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        mask      = 32'hFFFF_FFFF;
        load_data = rd_word;
      end
    endcase
    store_word = (rd_word & ~(mask << sh)) | ((new_data & mask) << sh);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end upstream of data_memory.
// Accepts byte/half/word requests, issues word-only reads/writes, performs
// read-modify-write for sub-word stores and flags misaligned/illegal sizes.
// Ports: clock, reset (async active-low), bus (mem_access_unit_if.slave:
// req_* handshake in, resp_* completion pulse out, dm_* to data_memory).
// All bus outputs decode from registered state only.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN     = 1'b1,
  parameter bit WORD_STORE_RMW = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  state_e      state, state_nxt;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [1:0]  size_q;
  logic        signed_q, we_q, err_q;
  logic        hs, req_err;
  logic [31:0] load_data, store_word;

  assign hs      = bus.req_valid && (state == IDLE);
  assign req_err = access_err(bus.req_size, bus.req_addr[1:0]);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request latch and read-data capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (hs) begin
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        we_q     <= bus.req_we;
        err_q    <= req_err;
      end
      if (state == READ) data_q <= bus.dm_rdata;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hs) begin
          if (req_err)                                   state_nxt = RESP;
          else if (!bus.req_we)                          state_nxt = READ;
          else if (bus.req_size == SZ_WORD && !WORD_STORE_RMW) state_nxt = WRITE;
          else                                           state_nxt = READ;
        end
      end
      READ:    state_nxt = we_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .rd_word    (data_q),
    .off        (addr_q[1:0]),
    .size       (size_q),
    .sgn        (signed_q),
    .new_data   (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Outputs
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.dm_addr    = '0;
    bus.dm_wdata   = '0;
    bus.dm_re      = 1'b0;
    bus.dm_we      = 1'b0;
    bus.dm_size    = SZ_WORD;
    case (state)
      IDLE: bus.req_ready = 1'b1;
      READ: begin
        bus.dm_re   = 1'b1;
        bus.dm_addr = {addr_q[31:2], 2'b00};
      end
      WRITE: begin
        // Full-word stores without RMW merge against a stale data_q, but the
        // all-ones mask makes the result equal to wdata_q anyway.
        bus.dm_we    = 1'b1;
        bus.dm_addr  = {addr_q[31:2], 2'b00};
        bus.dm_wdata = store_word;
      end
      default: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        if (!we_q && !err_q) bus.resp_rdata = load_data;
      end
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end sitting directly upstream of data_memory in the MEM stage.
- Accepts byte, halfword and word requests from the pipeline and issues word-only accesses to data_memory.
- Loads: extracts and sign/zero-extends sub-word data.
- Sub-word stores: performs read-modify-write.
- Detects misaligned accesses and reports completion with a valid/ready handshake.

Parameters:
- BIG_ENDIAN, 1, byte lane order; 1 = address offset 0 maps to bits [31:24], 0 = offset 0 maps to bits [7:0].
- WORD_STORE_RMW, 0, 1 = full-word stores also take the read-modify-write path (debug only).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 11 = word; 10 is illegal.
- req_signed  in  1  sign-extend a sub-word load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result.
- resp_err  out  1  misaligned or illegal size; qualified by resp_valid.
- dm_addr  out  32  word-aligned address to data_memory.
- dm_wdata  out  32  write word.
- dm_re  out  1  read enable.
- dm_we  out  1  write enable.
- dm_size  out  2  constant 2'b11.
- dm_rdata  in  32  combinational read data from data_memory.

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Request latch: req_ready = (state == IDLE). A handshake (req_valid & req_ready) latches the address, size, signed flag, we and wdata into registers.
- Transitions on handshake:
  - Error (half with addr[0] = 1, word with addr[1:0] != 0, or size 10) -> RESP with err = 1.
  - Load -> READ.
  - Word store with WORD_STORE_RMW = 0 -> WRITE.
  - Sub-word store -> READ.
- READ:
  - dm_re = 1, dm_addr = {addr[31:2], 2'b00}.
  - dm_rdata is captured at the cycle end.
  - Load -> RESP. Store -> WRITE.
- WRITE:
  - dm_we = 1, dm_wdata = the captured word with the addressed lane(s) replaced by req_wdata[7:0] or [15:0], or the full req_wdata for a word store.
  - Next state RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - Loads: resp_rdata = the extracted lane, sign-extended if req_signed, else zero-extended; word loads pass through unchanged.
  - Stores and errors: resp_rdata = 0.
  - Next state IDLE.
- Latencies (handshake edge = cycle 0; resp_valid high in the listed cycle):
  - Error: cycle 1.
  - Load: cycle 2.
  - Word store: cycle 2.
  - Sub-word store: cycle 3.
- Outputs decode only from registered state, with no combinational path from req_* to dm_*.
- dm_re and dm_we are never high together.
- An error request never asserts dm_re or dm_we.
- A new request is only accepted in IDLE, so back-to-back throughput is one request per 2–4 cycles.
- Reset (asynchronous, active-low): state = IDLE. All outputs 0, including dm_addr, dm_wdata and resp_rdata, except req_ready = 1 and dm_size = 11.
- Reset asserted mid-WRITE drops dm_we immediately. The partial request is discarded with no response.
- Addresses are not range-checked here; unmapped regions are data_memory's concern.

Decomposition:
- Shared package mem_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum.
  - Lane-index helper constants.
- One natural sub-module: mem_lane_align. It is combinational and handles:
  - Load extraction and extension, from word, offset, size and signed inputs.
  - Store merge, from old word, new data, offset and size inputs.
- The FSM stays in mem_access_unit.

Test Plan:
- Signed byte load: memory word 0x1000_0004 = 0x80FF7F01, load byte signed @0x10000004 (BIG_ENDIAN = 1) -> resp_rdata = 0xFFFFFF80 two cycles after handshake. Unsigned @0x10000006 -> 0x0000007F.
- Signed half load: load half signed @0x10000006 from the same word -> 0x00007F01. Offset 0 -> 0xFFFF80FF.
- Byte store read-modify-write: byte store 0xAB @0x10000005 into 0x80FF7F01 -> exactly one dm_re cycle then one dm_we cycle with dm_wdata = 0x80AB7F01; resp_valid at cycle 3; read-back matches.
- Misaligned word: word load @0x10000002 -> resp_err = 1 at cycle 1, dm_re and dm_we never asserted, resp_rdata = 0.
- Busy back-pressure: two back-to-back requests with req_valid held high -> req_ready low until after resp_valid; the second request is accepted in the cycle following RESP and completes correctly.
- Reset during write: assert reset while in WRITE -> dm_we falls without waiting for the clock; state IDLE, req_ready = 1, no resp_valid after release.
